// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM states,
// the x0 register index and the per-stage enable/flush bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // Canned control patterns, one per arbitration outcome.
    localparam stage_ctrl_t CTRL_NORMAL  = stage_ctrl_t'(8'b11111_000);
    localparam stage_ctrl_t CTRL_FREEZE  = stage_ctrl_t'(8'b00000_000);
    localparam stage_ctrl_t CTRL_MEMWAIT = stage_ctrl_t'(8'b00001_001);
    localparam stage_ctrl_t CTRL_MISPRED = stage_ctrl_t'(8'b11111_110);
    localparam stage_ctrl_t CTRL_LOADUSE = stage_ctrl_t'(8'b00111_010);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard request inputs and stage control outputs of the hazard controller.
// No handshake: inputs are sampled every cycle, outputs are valid every cycle.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic [4:0]       i_ex_rd;
    logic             i_ex_read;
    logic             i_ex_mispredict;
    logic             i_mem_req;
    logic             i_mem_ack;
    logic             o_pc_enable;
    logic             o_if_id_enable;
    logic             o_id_ex_enable;
    logic             o_ex_mem_enable;
    logic             o_mem_wb_enable;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_mem_wb_flush;
    logic             o_mem_timeout;
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_flush_count;
    state_t           state_dbg;

    modport master (
        output i_id_rs1, i_id_rs2, i_ex_rd, i_ex_read, i_ex_mispredict,
               i_mem_req, i_mem_ack,
        input  o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable,
               o_mem_wb_enable, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush,
               o_mem_timeout, o_stall_cycles, o_flush_count, state_dbg
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_ex_rd, i_ex_read, i_ex_mispredict,
               i_mem_req, i_mem_ack,
        output o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable,
               o_mem_wb_enable, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush,
               o_mem_timeout, o_stall_cycles, o_flush_count, state_dbg
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign o_count = count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage RV32I pipeline: arbitrates load-use,
// EX mispredict and multi-cycle MEM waits into per-stage enables/flushes.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input logic                  i_clk,
    input logic                  i_reset,
    pipeline_hazard_ctrl_if.slave bus
);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        timeout;
    logic        load_use;
    logic        mem_wait;
    logic        mispred_win;
    logic        stall_inc;
    stage_ctrl_t ctrl;

    always_comb begin
        load_use = bus.i_ex_read && (bus.i_ex_rd != REG_X0) &&
                   ((bus.i_ex_rd == bus.i_id_rs1) || (bus.i_ex_rd == bus.i_id_rs2));
        mem_wait = ((state == S_RUN) && bus.i_mem_req && !bus.i_mem_ack) ||
                   ((state == S_MEM_WAIT) && !bus.i_mem_ack);
    end

    // Priority: frozen error > memory wait > mispredict > load-use > normal.
    always_comb begin
        ctrl        = CTRL_NORMAL;
        mispred_win = 1'b0;
        if (!i_reset) begin
            ctrl = CTRL_NORMAL;
        end else if (state == S_ERR) begin
            ctrl = CTRL_FREEZE;
        end else if (mem_wait) begin
            ctrl = CTRL_MEMWAIT;
        end else if (bus.i_ex_mispredict) begin
            ctrl        = CTRL_MISPRED;
            mispred_win = 1'b1;
        end else if (load_use) begin
            ctrl = CTRL_LOADUSE;
        end
    end

    // wait_cnt holds the number of wait cycles already spent in this access.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.i_mem_req && !bus.i_mem_ack) begin
                        if (MAX_WAIT <= 1) begin
                            state   <= S_ERR;
                            timeout <= 1'b1;
                        end else begin
                            state    <= S_MEM_WAIT;
                            wait_cnt <= 8'd1;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.i_mem_ack) begin
                        state    <= S_RUN;
                        wait_cnt <= 8'd0;
                    end else if (({1'b0, wait_cnt} + 9'd1) >= 9'(MAX_WAIT)) begin
                        state   <= S_ERR;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_ERR;
            endcase
        end
    end

    assign stall_inc = !ctrl.pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (stall_inc),
        .o_count (bus.o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (mispred_win),
        .o_count (bus.o_flush_count)
    );

    assign bus.o_pc_enable     = ctrl.pc_en;
    assign bus.o_if_id_enable  = ctrl.if_id_en;
    assign bus.o_id_ex_enable  = ctrl.id_ex_en;
    assign bus.o_ex_mem_enable = ctrl.ex_mem_en;
    assign bus.o_mem_wb_enable = ctrl.mem_wb_en;
    assign bus.o_if_id_flush   = ctrl.if_id_flush;
    assign bus.o_id_ex_flush   = ctrl.id_ex_flush;
    assign bus.o_mem_wb_flush  = ctrl.mem_wb_flush;
    assign bus.o_mem_timeout   = timeout;
    assign bus.state_dbg       = state;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Arbitrates three request sources into one coherent set of per-stage register enables and flushes:
  - load-use data hazard (ID vs EX);
  - branch/jump misprediction resolved in EX;
  - multi-cycle data-memory access in MEM (req/ack).
- Also tracks memory-wait timeout and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of performance counters.
- MAX_WAIT, 16, max consecutive MEM wait cycles before timeout error (range 1..255).

Ports:
- i_clk  in  1  pipeline clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_id_rs1  in  5  rs1 of instruction in ID.
- i_id_rs2  in  5  rs2 of instruction in ID.
- i_ex_rd  in  5  rd of instruction in EX.
- i_ex_read  in  1  EX instruction is a load.
- i_ex_mispredict  in  1  EX resolved a control transfer whose PC differs from fetched path.
- i_mem_req  in  1  MEM instruction performs an LSU access this cycle.
- i_mem_ack  in  1  LSU completes the access this cycle.
- o_pc_enable  out  1  PC register update enable.
- o_if_id_enable  out  1  IF/ID register enable.
- o_id_ex_enable  out  1  ID/EX register enable.
- o_ex_mem_enable  out  1  EX/MEM register enable.
- o_mem_wb_enable  out  1  MEM/WB register enable.
- o_if_id_flush  out  1  IF/ID loads NOP.
- o_id_ex_flush  out  1  ID/EX loads NOP (bubble).
- o_mem_wb_flush  out  1  MEM/WB loads NOP.
- o_mem_timeout  out  1  sticky timeout error.
- o_stall_cycles  out  CNT_W  cycles with o_pc_enable=0.
- o_flush_count  out  CNT_W  mispredict flush events.

Behaviour:
- Outputs are combinational from state and inputs, except counters and o_mem_timeout, which are registered.
- Reset (i_reset=0 at edge):
  - state=S_RUN, wait counter=0, o_mem_timeout=0, both perf counters=0.
  - While i_reset=0, all enables=1 and all flushes=0.
- Load-use detection (lu): i_ex_read && i_ex_rd!=0 && (i_ex_rd==i_id_rs1 || i_ex_rd==i_id_rs2).
- Memory wait (mw): (state==S_RUN && i_mem_req && !i_mem_ack) || (state==S_MEM_WAIT && !i_mem_ack).
- Priority per cycle: S_ERR > mw > i_ex_mispredict > lu > normal.
  - S_ERR: all enables=0, all flushes=0 (pipeline frozen).
  - mw: all enables=0, all flushes=0, except o_mem_wb_enable=1 and o_mem_wb_flush=1 (WB sees NOP, no double writeback). A pending mispredict or load-use stays asserted because EX is frozen; it is serviced on the release cycle.
  - mispredict: all enables=1; o_if_id_flush=1, o_id_ex_flush=1. Load-use in the same cycle is ignored (its ID instruction is squashed).
  - lu: o_pc_enable=0, o_if_id_enable=0, others=1; o_id_ex_flush=1. Exactly one bubble, because the next cycle's EX holds the bubble (rd=0).
  - normal: all enables=1, flushes=0.
- FSM:
  - S_RUN -> S_MEM_WAIT when i_mem_req && !i_mem_ack; wait counter <= 1.
  - S_MEM_WAIT -> S_RUN when i_mem_ack. The ack cycle is a release cycle: mw=0, lower priorities apply.
  - S_MEM_WAIT, !i_mem_ack: wait counter increments. At counter==MAX_WAIT -> S_ERR and o_mem_timeout <= 1.
  - S_ERR holds until reset.
  - i_mem_req with i_mem_ack in the same S_RUN cycle is zero-wait: no state change.
- Counters:
  - o_stall_cycles +1 each cycle o_pc_enable=0 (lu, mw, S_ERR).
  - o_flush_count +1 each cycle the mispredict branch of the priority wins.
  - Both saturate at all-ones, no wrap.
- Reset mid-wait: next cycle in S_RUN with counters cleared; a still-asserted i_mem_req is treated as a new request.

Decomposition:
- Shared package hazard_pkg:
  - state enum (S_RUN, S_MEM_WAIT, S_ERR);
  - constant REG_X0=5'd0;
  - struct stage_ctrl_t {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}.
- Sub-module sat_counter (parameter W, inputs i_clk, i_reset, i_inc), instantiated twice for the perf counters.
- Load-use compare stays inline.

Test Plan:
- Load-use: i_ex_read=1, i_ex_rd=5, i_id_rs2=5 -> one cycle pc/if_id enable=0, id_ex_flush=1; next cycle (ex_rd=0) all enables=1; o_stall_cycles=1.
- x0 load: i_ex_read=1, i_ex_rd=0, i_id_rs1=0 -> no stall, o_stall_cycles stays 0.
- Memory wait: i_mem_req=1, ack after 3 cycles -> enables 0 for cycles 0-2, mem_wb_flush=1 in those cycles; release on ack cycle; o_stall_cycles=3.
- Mispredict held during wait: i_ex_mispredict=1 during a 2-cycle wait -> no flush while waiting; on ack cycle if_id_flush=id_ex_flush=1; o_flush_count=1.
- Mispredict + load-use same cycle -> flushes asserted, pc_enable=1, o_stall_cycles unchanged.
- Timeout: MAX_WAIT=4, i_mem_req=1, no ack -> o_mem_timeout=1 after 4th wait cycle, pipeline frozen; i_reset=0 for one edge clears everything.
